// File: rtl/mem_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter_pkg
// Description : Shared state encoding, response tags and depth default for
//               the fetch/load-store memory request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_req_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GNT_INST = 2'd1,
      GNT_DATA = 2'd2
   } arb_state_e;

   localparam logic TAG_INST = 1'b0;
   localparam logic TAG_DATA = 1'b1;

   localparam int unsigned FIFO_DEPTH_DEFAULT = 2;

endpackage
`default_nettype wire

// File: rtl/mem_req_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tag_fifo
// Description : 1-bit ordering FIFO recording which requester owns each
//               outstanding memory transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module tag_fifo
   import mem_req_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic clk,
   input  logic resetn,
   input  logic push,
   input  logic push_tag,
   input  logic pop,
   output logic full,
   output logic empty,
   output logic head
);

   localparam int unsigned            c_PTR_W     = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]       c_DEPTH_CNT = (c_PTR_W + 1)'(DEPTH);

   logic                r_mem [DEPTH];
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [c_PTR_W:0]    r_count;
   logic                w_push;
   logic                w_pop;

   // A push into a full FIFO is only honoured when a pop frees a slot.
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= push_tag;
   end

   assign full  = (r_count == c_DEPTH_CNT);
   assign empty = (r_count == '0);
   assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter
// Description : Arbitrates fetch and load/store SRAM-like requests onto one
//               memory port and routes in-order responses back by tag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter
   import mem_req_arbiter_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        resetn,
   // fetch side
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   // load/store side
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   // shared memory port
   output logic        req,
   output logic        wr,
   output logic [1:0]  size,
   output logic [3:0]  wstrb,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic        addr_ok,
   input  logic        data_ok,
   input  logic [31:0] rdata
);

   arb_state_e r_state;
   arb_state_e w_state_nxt;
   logic       r_last_grant;
   logic       w_accept;
   logic       w_push_tag;
   logic       w_fifo_full;
   logic       w_fifo_empty;
   logic       w_fifo_head;
   logic       w_rsp;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state      <= IDLE;
         r_last_grant <= TAG_INST;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) r_last_grant <= w_push_tag;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      req          = 1'b0;
      wr           = 1'b0;
      size         = 2'd0;
      wstrb        = 4'd0;
      addr         = 32'd0;
      wdata        = 32'd0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      w_accept     = 1'b0;
      w_push_tag   = TAG_INST;
      case (r_state)
         IDLE: begin
            // On conflict the side that lost last time wins.
            if (!w_fifo_full) begin
               if (inst_req && data_req)
                  w_state_nxt = (r_last_grant == TAG_INST) ? GNT_DATA : GNT_INST;
               else if (inst_req)
                  w_state_nxt = GNT_INST;
               else if (data_req)
                  w_state_nxt = GNT_DATA;
            end
         end
         GNT_INST: begin
            req          = 1'b1;
            wr           = inst_wr;
            size         = inst_size;
            wstrb        = inst_wstrb;
            addr         = inst_addr;
            wdata        = inst_wdata;
            inst_addr_ok = addr_ok;
            w_accept     = addr_ok;
            w_push_tag   = TAG_INST;
            if (addr_ok) w_state_nxt = IDLE;
         end
         GNT_DATA: begin
            req          = 1'b1;
            wr           = data_wr;
            size         = data_size;
            wstrb        = data_wstrb;
            addr         = data_addr;
            wdata        = data_wdata;
            data_addr_ok = addr_ok;
            w_accept     = addr_ok;
            w_push_tag   = TAG_DATA;
            if (addr_ok) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   tag_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_tag_fifo (
      .clk      (clk),
      .resetn   (resetn),
      .push     (w_accept),
      .push_tag (w_push_tag),
      .pop      (data_ok),
      .full     (w_fifo_full),
      .empty    (w_fifo_empty),
      .head     (w_fifo_head)
   );

   // A response with nothing outstanding is dropped silently.
   assign w_rsp        = data_ok && !w_fifo_empty;
   assign inst_data_ok = w_rsp && (w_fifo_head == TAG_INST);
   assign data_data_ok = w_rsp && (w_fifo_head == TAG_DATA);
   assign inst_rdata   = rdata;
   assign data_rdata   = rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_arbiter
// Description : Scoreboard bench for mem_req_arbiter: directed scenarios then
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [3:0]  inst_wstrb, data_wstrb;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        req, wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr, wdata;
   logic        addr_ok, data_ok;
   logic [31:0] rdata;

   mem_req_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
      .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        req;
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        iaok;
      logic        daok;
      logic        idok;
      logic        ddok;
      logic [31:0] rdata;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   // Reference model: current owner of the shared port (-1 none, 0 fetch,
   // 1 load/store), who won last, and the queue of outstanding owners.
   int   m_owner;
   bit   m_last;
   bit   m_q[$];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   // Advance the model across the edge that just happened, using the inputs
   // that were stable before it.
   task automatic model_edge();
      int sz;
      if (!resetn) begin
         m_owner = -1;
         m_last  = 1'b0;
         m_q.delete();
         return;
      end
      sz = m_q.size();
      if (data_ok && sz > 0) m_q.delete(0);
      if (m_owner >= 0) begin
         if (addr_ok) begin
            m_q.push_back(m_owner == 1);
            m_last  = (m_owner == 1);
            m_owner = -1;
         end
      end else if (sz < DEPTH) begin
         if (inst_req && data_req) m_owner = m_last ? 0 : 1;
         else if (inst_req)        m_owner = 0;
         else if (data_req)        m_owner = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_edge();
   endtask

   task automatic post();
      exp_t e;
      bit   own_d;
      own_d   = (m_owner == 1);
      e.req   = (m_owner >= 0);
      e.wr    = own_d ? data_wr    : inst_wr;
      e.size  = own_d ? data_size  : inst_size;
      e.wstrb = own_d ? data_wstrb : inst_wstrb;
      e.addr  = own_d ? data_addr  : inst_addr;
      e.wdata = own_d ? data_wdata : inst_wdata;
      e.iaok  = (m_owner == 0) && addr_ok;
      e.daok  = (m_owner == 1) && addr_ok;
      e.idok  = data_ok && (m_q.size() > 0) && (m_q[0] == 1'b0);
      e.ddok  = data_ok && (m_q.size() > 0) && (m_q[0] == 1'b1);
      e.rdata = rdata;
      expq.push_back(e);
   endtask

   task automatic cyc(input bit rn, input bit ir, input bit dr, input bit aok,
                      input bit dok, input logic [31:0] rd);
      tick();
      resetn   = rn;
      inst_req = ir;
      data_req = dr;
      addr_ok  = aok;
      data_ok  = dok;
      rdata    = rd;
      post();
   endtask

   always @(negedge clk) begin
      if (expq.size() > 0) begin
         mon_e = expq.pop_front();
         chk("req", {31'd0, req}, {31'd0, mon_e.req});
         if (mon_e.req) begin
            chk("wr", {31'd0, wr}, {31'd0, mon_e.wr});
            chk("size", {30'd0, size}, {30'd0, mon_e.size});
            chk("wstrb", {28'd0, wstrb}, {28'd0, mon_e.wstrb});
            chk("addr", addr, mon_e.addr);
            chk("wdata", wdata, mon_e.wdata);
         end
         chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, mon_e.iaok});
         chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, mon_e.daok});
         chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, mon_e.idok});
         chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, mon_e.ddok});
         chk("inst_rdata", inst_rdata, mon_e.rdata);
         chk("data_rdata", data_rdata, mon_e.rdata);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      m_owner = -1;
      m_last  = 1'b0;
      resetn = 1'b0; inst_req = 1'b0; data_req = 1'b0; addr_ok = 1'b0;
      data_ok = 1'b0; rdata = '0;
      inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'h0; inst_wdata = '0;
      inst_addr = 32'h1C00_0000;
      data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0; data_wdata = '0;
      data_addr = '0;

      // Reset, then single fetch
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 32'h02C0_0000);
      cyc(1, 0, 0, 0, 0, 0);

      // Conflict after reset: store wins first
      data_wr = 1'b1; data_wstrb = 4'hF; data_addr = 32'h0000_1000;
      data_wdata = 32'hDEAD_BEEF; inst_addr = 32'h1C00_0040;
      cyc(0, 0, 0, 0, 0, 0);
      cyc(1, 1, 1, 0, 0, 0);
      cyc(1, 1, 1, 1, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 1, 32'h1234_5678);
      cyc(1, 0, 0, 0, 1, 32'h8765_4321);

      // Ordering: fetch then load, responses in acceptance order
      data_wr = 1'b0; data_addr = 32'h0000_2000;
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      cyc(1, 0, 1, 0, 0, 0);
      cyc(1, 0, 1, 1, 0, 0);
      cyc(1, 0, 0, 0, 1, 32'h1111_1111);
      cyc(1, 0, 0, 0, 1, 32'h2222_2222);

      // Full FIFO blocks the third request until a response drains it
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      cyc(1, 0, 1, 0, 0, 0);
      cyc(1, 0, 1, 1, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 0, 1, 32'hAAAA_0001);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 1, 32'hAAAA_0002);
      cyc(1, 0, 0, 0, 1, 32'hAAAA_0003);

      // Simultaneous accept and response
      cyc(1, 0, 1, 0, 0, 0);
      cyc(1, 0, 1, 1, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      cyc(1, 1, 0, 1, 1, 32'hBBBB_0001);
      cyc(1, 0, 0, 0, 1, 32'hBBBB_0002);
      cyc(1, 0, 0, 0, 1, 32'hBBBB_0003);

      // Reset while granted with one outstanding, then a stray response
      cyc(1, 0, 1, 0, 0, 0);
      cyc(1, 0, 1, 1, 0, 0);
      cyc(1, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 32'hCCCC_0001);
      cyc(1, 0, 0, 0, 0, 0);

      // Randomized traffic; the granted side holds its request stable
      for (int n = 0; n < 3000; n++) begin
         tick();
         resetn = ($urandom_range(0, 149) != 0);
         if (m_owner != 0) begin
            inst_req   = $urandom_range(0, 1);
            inst_wr    = $urandom_range(0, 1);
            inst_size  = 2'($urandom_range(0, 3));
            inst_wstrb = 4'($urandom);
            inst_addr  = $urandom;
            inst_wdata = $urandom;
         end
         if (m_owner != 1) begin
            data_req   = $urandom_range(0, 1);
            data_wr    = $urandom_range(0, 1);
            data_size  = 2'($urandom_range(0, 3));
            data_wstrb = 4'($urandom);
            data_addr  = $urandom;
            data_wdata = $urandom;
         end
         addr_ok = ($urandom_range(0, 9) < 4);
         data_ok = ($urandom_range(0, 9) < 4);
         rdata   = $urandom;
         post();
      end

      cyc(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
